// File: rtl/chrom_pkg.sv
// Shared definitions for the chromosome loader and the genetic evaluator.
package chrom_pkg;

  // Evaluator geometry; both sides derive the chromosome width from it.
  localparam int unsigned ROW       = 3;
  localparam int unsigned COL       = 3;
  localparam int unsigned OUT       = 1;
  localparam int unsigned BITS_ELEM = 5;
  localparam int unsigned BITS_MUX  = 2;

  // Matrix field + output-select field + mux field = 45 + 2 + 2 = 49 bits.
  localparam int unsigned DEF_CHROM_BITS = ROW * COL * BITS_ELEM + OUT * BITS_MUX + BITS_MUX;

  // Frame start byte.
  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    COMMIT  = 2'd3
  } state_e;

endpackage

// File: rtl/frame_timeout.sv
// Idle-cycle counter used to abort a frame that stalls mid-transfer.
module frame_timeout #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Fires on the TIMEOUT-th consecutive idle cycle.
  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

  // Next count: clear wins, otherwise count idle cycles up to expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/chrom_loader.sv
// Reassembles a framed byte stream into a shadow chromosome, verifies the
// XOR checksum and commits the vector atomically to the evaluator.
module chrom_loader
  import chrom_pkg::*;
#(
  parameter int unsigned CHROM_BITS = chrom_pkg::DEF_CHROM_BITS,
  parameter int unsigned TIMEOUT    = 50000,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  eval_busy,
  output logic [CHROM_BITS-1:0] chrom,
  output logic                  chrom_valid,
  output logic                  load_pulse,
  output logic                  chk_err,
  output logic [CNT_W-1:0]      frame_cnt
);

  localparam int unsigned NBYTES = (CHROM_BITS + 7) / 8;
  localparam int unsigned SH_W   = NBYTES * 8;
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_e                state_q, state_d;
  logic [SH_W-1:0]       shadow_q, shadow_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            acc_q, acc_d;
  logic [CHROM_BITS-1:0] chrom_q, chrom_d;
  logic                  valid_q, valid_d;
  logic                  load_q, load_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic accept;
  logic in_frame;
  logic tmo_exp;

  assign in_ready = (state_q != COMMIT);
  assign accept   = in_valid && in_ready;
  assign in_frame = (state_q == PAYLOAD) || (state_q == CHECK);

  frame_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (!in_frame || accept),
    .en_i     (in_frame && !accept),
    .expired_o(tmo_exp)
  );

  // Frame FSM: next state, shadow/checksum update and commit decision.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    chrom_d  = chrom_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    load_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      HUNT: begin
        if (accept && in_data == SYNC) begin
          state_d = PAYLOAD;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          for (int unsigned k = 0; k < NBYTES; k++) begin
            if (idx_q == IDX_W'(k)) shadow_d[8*k +: 8] = in_data;
          end
          acc_d = acc_q ^ in_data;
          if (idx_q == IDX_W'(NBYTES - 1)) state_d = CHECK;
          else                             idx_d   = idx_q + IDX_W'(1);
        end else if (tmo_exp) begin
          err_d   = 1'b1;
          state_d = HUNT;
        end
      end
      CHECK: begin
        if (accept) begin
          if (in_data == acc_q) begin
            state_d = COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = HUNT;
          end
        end else if (tmo_exp) begin
          err_d   = 1'b1;
          state_d = HUNT;
        end
      end
      COMMIT: begin
        if (!eval_busy) begin
          chrom_d = shadow_q[CHROM_BITS-1:0];
          valid_d = 1'b1;
          load_d  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      shadow_q <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      chrom_q  <= '0;
      valid_q  <= 1'b0;
      load_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      chrom_q  <= chrom_d;
      valid_q  <= valid_d;
      load_q   <= load_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign chrom       = chrom_q;
  assign chrom_valid = valid_q;
  assign load_pulse  = load_q;
  assign chk_err     = err_q;
  assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_chrom_loader.sv
// Directed bench for chrom_loader: a 16-bit instance with a short timeout
// and a default-width (49-bit) instance.
module tb_chrom_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [7:0]  d16 = '0, d49 = '0;
  logic        v16 = 1'b0, v49 = 1'b0;
  logic        busy16 = 1'b0, busy49 = 1'b0;
  logic        rdy16, rdy49;
  logic [15:0] chrom16;
  logic [48:0] chrom49;
  logic        cv16, cv49, lp16, lp49, ce16, ce49;
  logic [7:0]  fc16, fc49;

  int total = 0;
  int bad   = 0;
  int lp16_n = 0;
  int ce16_n = 0;

  always #5 clk = ~clk;

  chrom_loader #(.CHROM_BITS(16), .TIMEOUT(20), .CNT_W(8)) u16 (
    .clk(clk), .rst_n(rst_n), .in_data(d16), .in_valid(v16), .in_ready(rdy16),
    .eval_busy(busy16), .chrom(chrom16), .chrom_valid(cv16), .load_pulse(lp16),
    .chk_err(ce16), .frame_cnt(fc16)
  );

  chrom_loader #(.CHROM_BITS(49), .CNT_W(8)) u49 (
    .clk(clk), .rst_n(rst_n), .in_data(d49), .in_valid(v49), .in_ready(rdy49),
    .eval_busy(busy49), .chrom(chrom49), .chrom_valid(cv49), .load_pulse(lp49),
    .chk_err(ce49), .frame_cnt(fc49)
  );

  // Pulse tallies for the 16-bit instance, sampled once per cycle.
  always @(negedge clk) begin
    if (lp16) lp16_n++;
    if (ce16) ce16_n++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte and hold it until the handshake edge.
  task automatic send(input int which, input logic [7:0] b);
    int unsigned n;
    n = 0;
    @(negedge clk);
    if (which == 0) begin
      d16 = b; v16 = 1'b1;
      while (!rdy16 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) check("ready_wait16", 64'(rdy16), 64'd1);
    end else begin
      d49 = b; v49 = 1'b1;
      while (!rdy49 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) check("ready_wait49", 64'(rdy49), 64'd1);
    end
    @(posedge clk);
    #1;
    v16 = 1'b0;
    v49 = 1'b0;
  endtask

  task automatic frame16(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] ck);
    send(0, 8'hA5);
    send(0, b0);
    send(0, b1);
    send(0, ck);
  endtask

  int lp_base;
  int ce_base;
  int first;
  logic [7:0] pay49 [7];

  initial begin
    pay49[0] = 8'h01; pay49[1] = 8'h23; pay49[2] = 8'h45; pay49[3] = 8'h67;
    pay49[4] = 8'h89; pay49[5] = 8'hAB; pay49[6] = 8'hFF;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_chrom", 64'(chrom16), 64'h0);
    check("rst_valid", 64'(cv16), 64'h0);
    check("rst_lp", 64'(lp16), 64'h0);
    check("rst_ce", 64'(ce16), 64'h0);
    check("rst_cnt", 64'(fc16), 64'h0);
    check("rst_rdy", 64'(rdy16), 64'h1);
    rst_n = 1'b1;

    // Good frame: 34^12 = 26.
    lp_base = lp16_n; ce_base = ce16_n;
    frame16(8'h34, 8'h12, 8'h26);
    @(negedge clk);
    check("good_lp_early", 64'(lp16), 64'h0);
    check("good_chrom_early", 64'(chrom16), 64'h0);
    @(negedge clk);
    check("good_lp", 64'(lp16), 64'h1);
    check("good_chrom", 64'(chrom16), 64'h1234);
    check("good_valid", 64'(cv16), 64'h1);
    check("good_cnt", 64'(fc16), 64'h1);
    @(negedge clk);
    check("good_lp_width", 64'(lp16), 64'h0);
    check("good_lp_count", 64'(lp16_n - lp_base), 64'd1);
    check("good_no_ce", 64'(ce16_n - ce_base), 64'd0);

    // Bad checksum leaves chrom untouched.
    frame16(8'h34, 8'h12, 8'h27);
    @(negedge clk);
    check("bad_ce", 64'(ce16), 64'h1);
    check("bad_no_lp", 64'(lp16), 64'h0);
    @(negedge clk);
    check("bad_ce_width", 64'(ce16), 64'h0);
    check("bad_chrom", 64'(chrom16), 64'h1234);
    check("bad_cnt", 64'(fc16), 64'h1);

    // Recovery frame: CD^AB = 66.
    frame16(8'hCD, 8'hAB, 8'h66);
    repeat (2) @(negedge clk);
    check("rec_chrom", 64'(chrom16), 64'hABCD);
    check("rec_cnt", 64'(fc16), 64'h2);

    // Garbage then a payload byte equal to SYNC: A5^01 = A4.
    ce_base = ce16_n;
    send(0, 8'h00);
    send(0, 8'hFF);
    frame16(8'hA5, 8'h01, 8'hA4);
    repeat (2) @(negedge clk);
    check("sync_chrom", 64'(chrom16), 64'h01A5);
    check("sync_cnt", 64'(fc16), 64'h3);
    check("sync_no_ce", 64'(ce16_n - ce_base), 64'd0);

    // Commit held off while the evaluator is busy.
    busy16 = 1'b1;
    frame16(8'h34, 8'h12, 8'h26);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("busy_rdy", 64'(rdy16), 64'h0);
      check("busy_chrom", 64'(chrom16), 64'h01A5);
    end
    busy16 = 1'b0;
    @(negedge clk);
    check("busy_lp", 64'(lp16), 64'h1);
    check("busy_chrom_new", 64'(chrom16), 64'h1234);
    check("busy_cnt", 64'(fc16), 64'h4);
    check("busy_rdy_back", 64'(rdy16), 64'h1);

    // Timeout: chk_err follows the 20th idle cycle after the last byte.
    send(0, 8'hA5);
    send(0, 8'h34);
    first = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (ce16 && first < 0) first = i;
    end
    check("tmo_cycle", 64'(first == 21 || first == 22), 64'd1);
    ce_base = ce16_n;
    send(0, 8'h12);
    send(0, 8'h26);
    repeat (3) @(negedge clk);
    check("tmo_hunt_cnt", 64'(fc16), 64'h4);
    check("tmo_hunt_chrom", 64'(chrom16), 64'h1234);
    check("tmo_hunt_no_ce", 64'(ce16_n - ce_base), 64'd0);

    // Reset mid-frame.
    send(0, 8'hA5);
    send(0, 8'h34);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_chrom", 64'(chrom16), 64'h0);
    check("mid_rst_valid", 64'(cv16), 64'h0);
    check("mid_rst_cnt", 64'(fc16), 64'h0);
    rst_n = 1'b1;
    frame16(8'hCD, 8'hAB, 8'h66);
    repeat (2) @(negedge clk);
    check("post_rst_chrom", 64'(chrom16), 64'hABCD);
    check("post_rst_cnt", 64'(fc16), 64'h1);

    // Default width: checksum must cover the full last byte (DD), so a
    // checksum computed over only the kept bit (23) is rejected.
    send(1, 8'hA5);
    for (int k = 0; k < 7; k++) send(1, pay49[k]);
    send(1, 8'h23);
    @(negedge clk);
    check("w49_bad_ce", 64'(ce49), 64'h1);
    check("w49_bad_valid", 64'(cv49), 64'h0);
    send(1, 8'hA5);
    for (int k = 0; k < 7; k++) send(1, pay49[k]);
    send(1, 8'hDD);
    repeat (2) @(negedge clk);
    check("w49_lp", 64'(lp49), 64'h1);
    check("w49_chrom", 64'(chrom49), 64'h1_AB89_6745_2301);
    check("w49_valid", 64'(cv49), 64'h1);
    check("w49_cnt", 64'(fc49), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
